// File: rtl/ctrl_trace_encoder_pkg.sv
// Shared opcode and trace-frame constants for the control-bundle trace encoder.
// Latency: n/a (constants only); frame length selected by macro TRACE_PC_EN.
// Backpressure: n/a.
package ctrl_trace_encoder_pkg;

    // RISC-V opcode classes, shared with the opcode decoder.
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ECALL     = 7'b1110011;
    localparam logic [6:0] OPC_ARITH     = 7'b0110011;
    localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OPC_NONE      = 7'b0000000;

    // Bit 7 of byte0 flags an inconsistent control bundle.
    localparam int TRACE_ERR_BIT = 7;

`ifdef TRACE_PC_EN
    localparam int TRACE_FRAME_BYTES = 5;
`else
    localparam int TRACE_FRAME_BYTES = 1;
`endif

    localparam int TRACE_REC_W = TRACE_FRAME_BYTES * 8;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } ser_state_t;

endpackage

// File: rtl/ctrl_trace_encoder_if.sv
// Retire-side control bundle plus byte-stream trace port.
// Latency: n/a (wiring only).
// Backpressure: tx_ready from the sink stalls the byte stream.
interface ctrl_trace_encoder_if;
    logic        retire_valid;
    logic        is_jal;
    logic        is_jalr;
    logic        branch;
    logic        mem_read;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        write_enable;
    logic        pc_to_reg;
    logic        is_ecall;
    logic [31:0] pc;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    // Core + sink side.
    modport master (
        output retire_valid, is_jal, is_jalr, branch, mem_read, mem_to_reg,
               mem_write, alu_src, write_enable, pc_to_reg, is_ecall, pc,
               tx_ready,
        input  tx_valid, tx_data
    );

    // Encoder side.
    modport slave (
        input  retire_valid, is_jal, is_jalr, branch, mem_read, mem_to_reg,
               mem_write, alu_src, write_enable, pc_to_reg, is_ecall, pc,
               tx_ready,
        output tx_valid, tx_data
    );
endinterface

// File: rtl/ctrl_trace_encoder_trace_fifo.sv
// Generic synchronous FIFO with full/empty flags.
// Latency: 1 cycle push-to-visible, no empty bypass.
// Backpressure: push while full is accepted only alongside a pop.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    // Pointers carry a wrap bit; reset flushes contents by realigning them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage; when full, the write lands in the slot being read out this cycle.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/ctrl_trace_encoder.sv
// Re-encodes retiring control bundles to opcode classes, flags inconsistencies, streams trace bytes (TRACE_PC_EN adds PC).
// Latency: 2 cycles from retire edge to first byte valid; bytes back-to-back within a frame.
// Backpressure: tx_ready stalls the serializer; records arriving at a full buffer are dropped and counted.
module ctrl_trace_encoder
    import ctrl_trace_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ctrl_trace_encoder_if.slave   trc,
    output logic [7:0]            drop_count,
    output logic                  err_seen
);
    localparam logic [2:0] LAST_IDX = 3'(TRACE_FRAME_BYTES - 1);

    logic [6:0]             opcode;
    logic                   err;
    logic [2:0]             cls_cnt;
    logic [TRACE_REC_W-1:0] rec;
    logic [TRACE_REC_W-1:0] fifo_dat;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic                   rec_drop;
    ser_state_t             state;
    ser_state_t             state_nxt;
    logic [2:0]             idx;
    logic [TRACE_REC_W-1:0] shreg;
    logic                   byte_acc;

    assign cls_cnt = 3'(trc.is_jal) + 3'(trc.is_jalr) + 3'(trc.branch)
                   + 3'(trc.mem_read) + 3'(trc.mem_write) + 3'(trc.is_ecall);

    // Priority re-encode of the control bundle to its opcode class.
    always_comb begin
        opcode = OPC_NONE;
        if (trc.is_jal)                             opcode = OPC_JAL;
        else if (trc.is_jalr)                       opcode = OPC_JALR;
        else if (trc.branch)                        opcode = OPC_BRANCH;
        else if (trc.mem_read)                      opcode = OPC_LOAD;
        else if (trc.mem_write)                     opcode = OPC_STORE;
        else if (trc.is_ecall)                      opcode = OPC_ECALL;
        else if (trc.write_enable && !trc.alu_src)  opcode = OPC_ARITH;
        else if (trc.write_enable && trc.alu_src)   opcode = OPC_ARITH_IMM;
    end

    // Consistency check: any rule violation marks the record.
    always_comb begin
        err = 1'b0;
        if (cls_cnt > 3'd1)                                      err = 1'b1;
        if (trc.mem_to_reg != trc.mem_read)                      err = 1'b1;
        if (trc.pc_to_reg != (trc.is_jal | trc.is_jalr))         err = 1'b1;
        if (trc.write_enable && (trc.branch || trc.mem_write || trc.is_ecall))
                                                                 err = 1'b1;
        if (!trc.alu_src && opcode != OPC_ARITH && opcode != OPC_BRANCH)
                                                                 err = 1'b1;
        if (opcode == OPC_NONE)                                  err = 1'b1;
    end

    // Byte0 sits in the low byte so the frame shifts out LSB-first.
`ifdef TRACE_PC_EN
    assign rec = {trc.pc, err, opcode};
`else
    logic unused_pc;
    assign unused_pc = ^trc.pc;
    assign rec = {err, opcode};
`endif

    trace_fifo #(
        .WIDTH (TRACE_REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (trc.retire_valid),
        .push_dat (rec),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rec_drop = trc.retire_valid & fifo_full & ~fifo_pop;

    // Drop counter (saturating) and sticky error flag, updated at encode time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= 8'd0;
            err_seen   <= 1'b0;
        end else begin
            if (rec_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            if (trc.retire_valid && err)         err_seen   <= 1'b1;
        end
    end

    // Serializer next-state: pop when idle, advance on each accepted byte.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        byte_acc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (trc.tx_ready) begin
                    byte_acc = 1'b1;
                    if (idx == LAST_IDX) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Serializer state, byte index and shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            idx   <= 3'd0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            if (fifo_pop) begin
                shreg <= fifo_dat;
                idx   <= 3'd0;
            end else if (byte_acc) begin
                shreg <= shreg >> 8;
                idx   <= idx + 3'd1;
            end
        end
    end

    assign trc.tx_valid = (state == ST_SEND);
    assign trc.tx_data  = shreg[7:0];
endmodule

// File: tb/tb_ctrl_trace_encoder.sv
module tb_ctrl_trace_encoder;
    import ctrl_trace_encoder_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [7:0] drop_count;
    logic       err_seen;
    int         n_checks;
    int         n_fail;

    ctrl_trace_encoder_if trc();

    ctrl_trace_encoder #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trc        (trc),
        .drop_count (drop_count),
        .err_seen   (err_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bundle bit order: jal jalr branch mem_read mem_to_reg mem_write alu_src we pc_to_reg ecall
    localparam logic [9:0] C_JAL   = 10'b1000001110;
    localparam logic [9:0] C_ARITH = 10'b0000000100;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_retire(input logic [9:0] c, input logic [31:0] pc_v);
        {trc.is_jal, trc.is_jalr, trc.branch, trc.mem_read, trc.mem_to_reg,
         trc.mem_write, trc.alu_src, trc.write_enable, trc.pc_to_reg, trc.is_ecall} = c;
        trc.pc = pc_v;
        trc.retire_valid = 1'b1;
        step();
        trc.retire_valid = 1'b0;
        {trc.is_jal, trc.is_jalr, trc.branch, trc.mem_read, trc.mem_to_reg,
         trc.mem_write, trc.alu_src, trc.write_enable, trc.pc_to_reg, trc.is_ecall} = '0;
        trc.pc = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        trc.retire_valid = 1'b0;
        {trc.is_jal, trc.is_jalr, trc.branch, trc.mem_read, trc.mem_to_reg,
         trc.mem_write, trc.alu_src, trc.write_enable, trc.pc_to_reg, trc.is_ecall} = '0;
        trc.pc = '0;
        trc.tx_ready = 1'b0;
        step();
        step();
        n_checks++;
        if (trc.tx_valid !== 1'b0 || trc.tx_data !== 8'h00 || drop_count !== 8'h00 || err_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: valid=%b data=%h drop=%0d err=%b want 0/00/0/0",
                     trc.tx_valid, trc.tx_data, drop_count, err_seen);
        end
        reset_n = 1'b1;
        step();
        n_checks++;
        if (trc.tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: valid=%b want 0", trc.tx_valid);
        end
    endtask

    task automatic test_jal();
        logic [39:0] frame;
        frame = {32'h0000_1234, 8'h6F};
        trc.tx_ready = 1'b1;
        do_retire(C_JAL, 32'h0000_1234);
        n_checks++;
        if (trc.tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL jal_latency_early: valid=%b one cycle after retire, want 0", trc.tx_valid);
        end
        step();
        for (int i = 0; i < TRACE_FRAME_BYTES; i++) begin
            n_checks++;
            if (trc.tx_valid !== 1'b1 || trc.tx_data !== frame[8*i +: 8]) begin
                n_fail++;
                $display("FAIL jal_byte%0d: valid=%b data=%h want 1/%h", i, trc.tx_valid, trc.tx_data, frame[8*i +: 8]);
            end
            step();
        end
        n_checks++;
        if (trc.tx_valid !== 1'b0 || err_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL jal_end: valid=%b err_seen=%b want 0/0", trc.tx_valid, err_seen);
        end
    endtask

    task automatic test_stall();
        logic [39:0] frame;
        frame = {32'hCAFE_0001, 8'h33};
        trc.tx_ready = 1'b0;
        do_retire(C_ARITH, 32'hCAFE_0001);
        step();
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (trc.tx_valid !== 1'b1 || trc.tx_data !== 8'h33) begin
                n_fail++;
                $display("FAIL stall_hold%0d: valid=%b data=%h want 1/33", c, trc.tx_valid, trc.tx_data);
            end
            if (c < 2) step();
        end
        trc.tx_ready = 1'b1;
        for (int i = 0; i < TRACE_FRAME_BYTES; i++) begin
            n_checks++;
            if (trc.tx_valid !== 1'b1 || trc.tx_data !== frame[8*i +: 8]) begin
                n_fail++;
                $display("FAIL stall_byte%0d: valid=%b data=%h want 1/%h", i, trc.tx_valid, trc.tx_data, frame[8*i +: 8]);
            end
            step();
        end
        n_checks++;
        if (trc.tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: valid=%b want 0", trc.tx_valid);
        end
    endtask

    task automatic test_encoding();
        logic [9:0] tbl_ctrl [10] = '{
            10'b0000001001, // ECALL
            10'b0000011000, // STORE
            10'b0010000000, // BRANCH
            10'b0000001100, // ARITH_IMM
            10'b0100001110, // JALR
            10'b0001101100, // LOAD, consistent
            10'b0001001000, // LOAD without mem_to_reg
            10'b1010001110, // JAL + BRANCH conflict
            10'b0000000000, // empty bundle
            10'b0000000100  // ARITH, err_seen stays set
        };
        logic [7:0] tbl_b0 [10] = '{8'h73, 8'h23, 8'h63, 8'h13, 8'h67, 8'h03, 8'h83, 8'hEF, 8'h80, 8'h33};
        logic       tbl_es [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] pc_v;
        logic [39:0] frame;
        trc.tx_ready = 1'b1;
        for (int r = 0; r < 10; r++) begin
            pc_v = 32'h8765_4300 + 32'(r * 17);
            frame = {pc_v, tbl_b0[r]};
            do_retire(tbl_ctrl[r], pc_v);
            step();
            for (int i = 0; i < TRACE_FRAME_BYTES; i++) begin
                n_checks++;
                if (trc.tx_valid !== 1'b1 || trc.tx_data !== frame[8*i +: 8]) begin
                    n_fail++;
                    $display("FAIL enc_row%0d_byte%0d: valid=%b data=%h want 1/%h",
                             r, i, trc.tx_valid, trc.tx_data, frame[8*i +: 8]);
                end
                step();
            end
            n_checks++;
            if (trc.tx_valid !== 1'b0 || err_seen !== tbl_es[r]) begin
                n_fail++;
                $display("FAIL enc_row%0d_end: valid=%b err_seen=%b want 0/%b", r, trc.tx_valid, err_seen, tbl_es[r]);
            end
        end
    endtask

    task automatic test_drop();
        trc.tx_ready = 1'b0;
        for (int k = 0; k < 8; k++) do_retire(C_ARITH, 32'h0000_D000 + 32'(k));
        n_checks++;
        if (drop_count !== 8'd3) begin
            n_fail++;
            $display("FAIL drop_after_8: drop_count=%0d want 3", drop_count);
        end
        n_checks++;
        if (trc.tx_valid !== 1'b1 || trc.tx_data !== 8'h33) begin
            n_fail++;
            $display("FAIL drop_head: valid=%b data=%h want 1/33", trc.tx_valid, trc.tx_data);
        end
        for (int k = 0; k < 250; k++) do_retire(C_ARITH, 32'h0000_E000);
        n_checks++;
        if (drop_count !== 8'd253) begin
            n_fail++;
            $display("FAIL drop_after_258: drop_count=%0d want 253", drop_count);
        end
        for (int k = 0; k < 42; k++) do_retire(C_ARITH, 32'h0000_E000);
        n_checks++;
        if (drop_count !== 8'd255) begin
            n_fail++;
            $display("FAIL drop_saturate: drop_count=%0d want 255", drop_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic seen;
        trc.tx_ready = 1'b1;
        step();
        step();
        trc.tx_ready = 1'b0;
        n_checks++;
        if (trc.tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: valid=%b want 1", trc.tx_valid);
        end
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (trc.tx_valid !== 1'b0 || trc.tx_data !== 8'h00 || drop_count !== 8'd0 || err_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: valid=%b data=%h drop=%0d err=%b want 0/00/0/0",
                     trc.tx_valid, trc.tx_data, drop_count, err_seen);
        end
        step();
        step();
        reset_n = 1'b1;
        trc.tx_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (trc.tx_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_stale: valid seen=%b want 0", seen);
        end
        do_retire(C_JAL, 32'h0000_0040);
        step();
        n_checks++;
        if (trc.tx_valid !== 1'b1 || trc.tx_data !== 8'h6F || err_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_recover: valid=%b data=%h err=%b want 1/6F/0", trc.tx_valid, trc.tx_data, err_seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_jal();
        test_stall();
        test_encoding();
        test_drop();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
